// File: rtl/booth_ctrl_pkg.sv
// Shared definitions for the Booth multiplier controller: the FSM state
// encoding and the {q0,q_1} recoding pairs that select add or subtract.
package booth_pkg;

  // The encoding is fixed because it is visible on the debug state port.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD   = 4'd1,
    ST_TEST   = 4'd2,
    ST_ADD    = 4'd3,
    ST_SUB    = 4'd4,
    ST_SHIFT  = 4'd5,
    ST_OUT_HI = 4'd6,
    ST_OUT_LO = 4'd7,
    ST_DONE   = 4'd8
  } state_t;

  // Booth decision pairs {q0,q_1}. The pairs 00 and 11 mean "shift only".
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_ctrl_if.sv
// Handshake and datapath-control bundle between booth_ctrl and the
// A/Q/M datapath plus the start/done requester.
// master: the controller side. slave: the datapath/requester side.
interface booth_ctrl_if;

  logic start;
  logic q0;
  logic q_1;
  logic ld_en;
  logic add_en;
  logic sub_en;
  logic shift_en;
  logic out_hi;
  logic out_lo;
  logic busy;
  logic done;

  modport master (
    input  start, q0, q_1,
    output ld_en, add_en, sub_en, shift_en, out_hi, out_lo, busy, done
  );

  modport slave (
    output start, q0, q_1,
    input  ld_en, add_en, sub_en, shift_en, out_hi, out_lo, busy, done
  );

endinterface

// File: rtl/booth_ctrl_iter_counter.sv
// Iteration counter for the Booth loop. A synchronous clear takes
// priority over counting up.
module iter_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             clear,
  input  logic             c_up,
  output logic [CNT_W-1:0] count
);

  // The counter register: it is cleared on reset and on clear, and it increments on c_up.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (c_up) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/booth_ctrl.sv
// Radix-2 Booth sequential multiplier controller (Moore FSM).
// Sequences an external A/Q/M datapath through load, add/sub, arithmetic
// shift and a two-phase result readout, then pulses done for one cycle.
// Optional debug ports (dbg_state, dbg_iter) exist only when
// BOOTH_CTRL_DBG_EN is defined. Behaviour is otherwise identical.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst_b,
  booth_ctrl_if.master      bus
`ifdef BOOTH_CTRL_DBG_EN
  ,
  output logic [3:0]        dbg_state,
  output logic [CNT_W-1:0]  dbg_iter
`endif
);

  // The comparison happens before the increment, so the last shift is the
  // one that sees WIDTH-1.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             cnt_clr;
  logic             cnt_up;
  logic [CNT_W-1:0] iter;

  iter_counter #(.CNT_W(CNT_W)) u_iter (
    .clk   (clk),
    .rst_b (rst_b),
    .clear (cnt_clr),
    .c_up  (cnt_up),
    .count (iter)
  );

  // The state register. An asynchronous reset returns it to IDLE, which forces every output low at once.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and Moore output decode. All strobes come only from the current state.
  always_comb begin
    state_nxt    = state;
    bus.ld_en    = 1'b0;
    bus.add_en   = 1'b0;
    bus.sub_en   = 1'b0;
    bus.shift_en = 1'b0;
    bus.out_hi   = 1'b0;
    bus.out_lo   = 1'b0;
    bus.done     = 1'b0;
    cnt_clr      = 1'b0;
    cnt_up       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        bus.ld_en = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = ST_TEST;
      end
      ST_TEST: begin
        case ({bus.q0, bus.q_1})
          BOOTH_SUB: state_nxt = ST_SUB;
          BOOTH_ADD: state_nxt = ST_ADD;
          default:   state_nxt = ST_SHIFT;
        endcase
      end
      ST_ADD: begin
        bus.add_en = 1'b1;
        state_nxt  = ST_SHIFT;
      end
      ST_SUB: begin
        bus.sub_en = 1'b1;
        state_nxt  = ST_SHIFT;
      end
      ST_SHIFT: begin
        bus.shift_en = 1'b1;
        cnt_up       = 1'b1;
        state_nxt    = (iter == LAST_ITER) ? ST_OUT_HI : ST_TEST;
      end
      ST_OUT_HI: begin
        bus.out_hi = 1'b1;
        state_nxt  = ST_OUT_LO;
      end
      ST_OUT_LO: begin
        bus.out_lo = 1'b1;
        state_nxt  = ST_DONE;
      end
      ST_DONE: begin
        bus.done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    bus.busy = (state != ST_IDLE);
  end

`ifdef BOOTH_CTRL_DBG_EN
  assign dbg_state = state;
  assign dbg_iter  = iter;
`endif

endmodule

// File: tb/tb_booth_ctrl.sv
// Testbench for booth_ctrl: a behavioural A/Q/M datapath driven by the
// controller strobes, a table of hand-computed multiplications, and
// directed sequences for start-while-busy, mid-operation reset and
// back-to-back operations.
module tb_booth_ctrl;

  logic clk;
  logic rst_b;
  int   assertions;
  int   failures;
  int   cycleCount;

  logic [7:0] opM;
  logic [7:0] opQ;
  logic [7:0] regA;
  logic [7:0] regQ;
  logic [7:0] regM;
  logic       regQm1;
  logic [7:0] resHi;
  logic [7:0] resLo;

  booth_ctrl_if bus();

`ifdef BOOTH_CTRL_DBG_EN
  logic [3:0] dbgState;
  logic [2:0] dbgIter;
`endif

  booth_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
`ifdef BOOTH_CTRL_DBG_EN
    ,
    .dbg_state (dbgState),
    .dbg_iter  (dbgIter)
`endif
  );

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] product;
    int          nAdd;
    int          nSub;
    int          latency;
  } vec_t;

  typedef struct {
    int latency;
    int nLd;
    int nAdd;
    int nSub;
    int nShift;
    int nDone;
    int oneHotErr;
    int ldCycle;
    int doneCycle;
    bit timedOut;
    bit resetHit;
    bit resetOutsZero;
  } opRes_t;

  vec_t vecs[7];

  // The clock, with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A free-running cycle counter. It is used to measure the distance between events.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // The behavioural 8-bit Booth datapath. It reacts to the controller strobes.
  always @(posedge clk) begin
    if (bus.ld_en) begin
      regA   <= 8'h00;
      regQ   <= opQ;
      regM   <= opM;
      regQm1 <= 1'b0;
    end else if (bus.add_en) begin
      regA <= regA + regM;
    end else if (bus.sub_en) begin
      regA <= regA - regM;
    end else if (bus.shift_en) begin
      {regA, regQ, regQm1} <= {regA[7], regA, regQ};
    end
    if (bus.out_hi) resHi <= regA;
    if (bus.out_lo) resLo <= regQ;
  end

  assign bus.q0  = regQ[0];
  assign bus.q_1 = regQm1;

  function automatic logic [7:0] outVec();
    return {bus.ld_en, bus.add_en, bus.sub_en, bus.shift_en,
            bus.out_hi, bus.out_lo, bus.busy, bus.done};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Loads the operands and holds start high across exactly one rising edge.
  task automatic applyStimulus(input logic [7:0] m, input logic [7:0] q);
    opM = m;
    opQ = q;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Follows one operation from the cycle after the start edge until done.
  // Optional actions: pulse start after shift number pokeShiftIter, pulse
  // start during DONE, or assert reset during the ADD of resetAddIter.
  task automatic waitDone(input int pokeShiftIter, input bit pokeDone,
                          input int resetAddIter, output opRes_t r);
    bit pokeLive;
    pokeLive = 1'b0;
    r = '{default: 0};
    r.latency = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (pokeLive) begin
        bus.start = 1'b0;
        pokeLive  = 1'b0;
      end
      if (!$onehot0({bus.ld_en, bus.add_en, bus.sub_en, bus.shift_en,
                     bus.out_hi, bus.out_lo, bus.done})) r.oneHotErr++;
      if (bus.ld_en) begin
        r.nLd++;
        r.ldCycle = cycleCount;
      end
      if (bus.add_en) r.nAdd++;
      if (bus.sub_en) r.nSub++;
      if (bus.shift_en) r.nShift++;
      if (pokeShiftIter > 0 && bus.shift_en && r.nShift == pokeShiftIter) begin
        bus.start = 1'b1;
        pokeLive  = 1'b1;
      end
      if (resetAddIter > 0 && bus.add_en && r.nShift == resetAddIter - 1) begin
        rst_b = 1'b0;
        #1;
        r.resetOutsZero = (outVec() == 8'h00);
        r.resetHit = 1'b1;
        return;
      end
      if (bus.done) begin
        r.nDone++;
        r.latency   = c;
        r.doneCycle = cycleCount;
        if (pokeDone) begin
          bus.start = 1'b1;
          @(posedge clk);
          #1;
          bus.start = 1'b0;
        end
        return;
      end
    end
    r.timedOut = 1'b1;
  endtask

  initial begin
    opRes_t r;
    opRes_t r2;
    logic [7:0]  acc;
    int          extraDone;
    logic [15:0] firstProduct;

    assertions = 0;
    failures   = 0;
    cycleCount = 0;
    opM = 8'h00;
    opQ = 8'h00;
    bus.start = 1'b0;
    rst_b = 1'b0;

    // The table of hand-computed results. k is the number of add/sub cycles, and the latency is 20 + k.
    vecs[0] = '{m: 8'h07, q: 8'hFD, product: 16'hFFEB, nAdd: 1, nSub: 2, latency: 23};
    vecs[1] = '{m: 8'h05, q: 8'h00, product: 16'h0000, nAdd: 0, nSub: 0, latency: 20};
    vecs[2] = '{m: 8'h03, q: 8'h55, product: 16'h00FF, nAdd: 4, nSub: 4, latency: 28};
    vecs[3] = '{m: 8'hFF, q: 8'h80, product: 16'h0080, nAdd: 0, nSub: 1, latency: 21};
    vecs[4] = '{m: 8'h9C, q: 8'h7F, product: 16'hCE64, nAdd: 1, nSub: 1, latency: 22};
    vecs[5] = '{m: 8'h0C, q: 8'hF0, product: 16'hFF40, nAdd: 0, nSub: 1, latency: 21};
    vecs[6] = '{m: 8'hF9, q: 8'h06, product: 16'hFFD6, nAdd: 1, nSub: 1, latency: 22};

    // Reset behaviour: all outputs are low while reset is held, and the FSM stays idle after release with start low.
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 32'(outVec()), 32'h0);
    rst_b = 1'b1;
    acc = 8'h00;
    repeat (10) begin
      @(negedge clk);
      acc |= outVec();
    end
    checkOutput("idle_after_reset", 32'(acc), 32'h0);

    // The table-driven multiplications.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].m, vecs[i].q);
      waitDone(-1, 1'b0, -1, r);
      $display("[TB] vector %0d: M=%0h Q=%0h -> %0h", i, vecs[i].m, vecs[i].q, {resHi, resLo});
      checkOutput($sformatf("v%0d_product", i), 32'({resHi, resLo}), 32'(vecs[i].product));
      checkOutput($sformatf("v%0d_latency", i), 32'(r.latency), 32'(vecs[i].latency));
      checkOutput($sformatf("v%0d_add", i), 32'(r.nAdd), 32'(vecs[i].nAdd));
      checkOutput($sformatf("v%0d_sub", i), 32'(r.nSub), 32'(vecs[i].nSub));
      checkOutput($sformatf("v%0d_shift", i), 32'(r.nShift), 32'd8);
      checkOutput($sformatf("v%0d_ld", i), 32'(r.nLd), 32'd1);
      checkOutput($sformatf("v%0d_done", i), 32'(r.nDone), 32'd1);
      checkOutput($sformatf("v%0d_onehot", i), 32'(r.oneHotErr), 32'd0);
    end

    // Start pulsed during the third SHIFT and again during DONE: the operation must not restart.
    @(negedge clk);
    applyStimulus(8'h07, 8'hFD);
    waitDone(3, 1'b1, -1, r);
    extraDone = 0;
    acc = 8'h00;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) extraDone++;
      acc |= outVec();
    end
    checkOutput("poke_product", 32'({resHi, resLo}), 32'hFFEB);
    checkOutput("poke_latency", 32'(r.latency), 32'd23);
    checkOutput("poke_ld_count", 32'(r.nLd), 32'd1);
    checkOutput("poke_done_total", 32'(r.nDone + extraDone), 32'd1);
    checkOutput("poke_idle_after", 32'(acc), 32'h0);

    // Reset asserted in the ADD of iteration 5 (Q=AA): outputs drop immediately, and the next operation is normal.
    @(negedge clk);
    applyStimulus(8'h03, 8'hAA);
    waitDone(-1, 1'b0, 5, r);
    checkOutput("rst_mid_hit", 32'(r.resetHit), 32'd1);
    checkOutput("rst_mid_outputs", 32'(r.resetOutsZero), 32'd1);
    @(negedge clk);
    rst_b = 1'b1;
    acc = 8'h00;
    repeat (3) begin
      @(negedge clk);
      acc |= outVec();
    end
    checkOutput("rst_no_done", 32'(acc), 32'h0);
    applyStimulus(8'h07, 8'hFD);
    waitDone(-1, 1'b0, -1, r);
    checkOutput("rst_recover_product", 32'({resHi, resLo}), 32'hFFEB);
    checkOutput("rst_recover_latency", 32'(r.latency), 32'd23);

    // Back-to-back: the second start is asserted in the first IDLE cycle after done.
    @(negedge clk);
    applyStimulus(8'h03, 8'h55);
    waitDone(-1, 1'b0, -1, r);
    firstProduct = {resHi, resLo};
    @(posedge clk);
    #1;
    checkOutput("b2b_idle_busy", 32'(bus.busy), 32'd0);
    applyStimulus(8'hFF, 8'h80);
    waitDone(-1, 1'b0, -1, r2);
    checkOutput("b2b_first_product", 32'(firstProduct), 32'h00FF);
    checkOutput("b2b_first_latency", 32'(r.latency), 32'd28);
    checkOutput("b2b_ld_gap", 32'(r2.ldCycle - r.doneCycle), 32'd2);
    checkOutput("b2b_second_product", 32'({resHi, resLo}), 32'h0080);
    checkOutput("b2b_second_latency", 32'(r2.latency), 32'd21);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
